// File: rtl/mlaccel_spi_slave.sv
// mlaccel_spi_slave: SPI mode-3 responder front-end (MSB first, CSB active low) in the system clock domain.
// Ports: clock/resetn system clock and async active-low reset; spi_csb/spi_clk/spi_mosi async pad inputs;
// spi_miso/spi_miso_oe pad output and tristate enable; rx_valid/rx_data/rx_first received-byte strobe;
// tx_data/tx_valid/tx_ready response-byte handshake; frame_active/frame_end framing status.
module mlaccel_spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       spi_csb,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       frame_active,
  output logic       frame_end
);
  localparam int FW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;
  localparam int SW = $clog2(SYNC_STAGES + 1);
  typedef enum logic [1:0] {S_WAIT, S_IDLE, S_ACTIVE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] csb_q, clk_q, mosi_q;
  logic [FW-1:0] flt_cnt;
  logic [SW-1:0] flush_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sh, tx_sh;
  logic clk_f, clk_fd, first_pending;
  logic csb_s, clk_s, mosi_s, flushed, rise, fall, start, stop;
  assign csb_s = csb_q[SYNC_STAGES-1];
  assign clk_s = clk_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign flushed = flush_cnt == SW'(SYNC_STAGES);
  assign rise = clk_f & ~clk_fd;
  assign fall = ~clk_f & clk_fd;
  assign start = state == S_IDLE && !csb_s;
  assign stop = state == S_ACTIVE && csb_s;
  // The synchronizer preset looks like CSB high, so a frame may only start once the
  // preset has been flushed and real CSB has been seen high; this keeps a reset
  // released mid-frame from locking onto the tail of that frame.
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      csb_q <= '1;
      clk_q <= '1;
      mosi_q <= '0;
      clk_f <= 1'b1;
      clk_fd <= 1'b1;
      flt_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      csb_q <= {csb_q[SYNC_STAGES-2:0], spi_csb};
      clk_q <= {clk_q[SYNC_STAGES-2:0], spi_clk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      clk_fd <= clk_f;
      if (clk_s == clk_f) flt_cnt <= '0;
      else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f <= clk_s;
        flt_cnt <= '0;
      end else flt_cnt <= flt_cnt + 1'b1;
      if (!flushed) flush_cnt <= flush_cnt + 1'b1;
    end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= S_WAIT;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == S_WAIT ? (flushed && csb_s ? S_IDLE : S_WAIT) : (csb_s ? S_IDLE : S_ACTIVE);
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      spi_miso <= 1'b0;
      spi_miso_oe <= 1'b0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_first <= 1'b0;
      tx_ready <= 1'b0;
      frame_active <= 1'b0;
      frame_end <= 1'b0;
      bit_cnt <= '0;
      rx_sh <= '0;
      tx_sh <= '0;
      first_pending <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      frame_end <= 1'b0;
      if (start) begin
        frame_active <= 1'b1;
        bit_cnt <= '0;
        first_pending <= 1'b1;
        tx_sh <= IDLE_BYTE;
        spi_miso_oe <= 1'b1;
        spi_miso <= IDLE_BYTE[7];
      end else if (stop) begin
        frame_end <= 1'b1;
        frame_active <= 1'b0;
        spi_miso_oe <= 1'b0;
        spi_miso <= 1'b0;
      end else if (state == S_ACTIVE && rise) begin
        rx_sh <= {rx_sh[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_valid <= 1'b1;
          rx_data <= {rx_sh[6:0], mosi_s};
          rx_first <= first_pending;
          first_pending <= 1'b0;
          tx_ready <= 1'b1;
          tx_sh <= tx_valid ? tx_data : IDLE_BYTE;
        end
      end else if (state == S_ACTIVE && fall) begin
        spi_miso <= tx_sh[7];
        tx_sh <= {tx_sh[6:0], 1'b0};
      end
    end
endmodule

// File: tb/tb_mlaccel_spi_slave.sv
// tb_mlaccel_spi_slave: directed and randomized SPI frames against a byte-level host/core model.
module tb_mlaccel_spi_slave;
  localparam int H = 8;
  localparam logic [7:0] IDLE = 8'h00;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic spi_csb = 1'b1, spi_clk = 1'b1, spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, rx_valid, rx_first, tx_valid = 1'b0, tx_ready, frame_active, frame_end;
  logic [7:0] rx_data, tx_data = 8'h00;
  int checks = 0, failures = 0;
  int tx_cnt = 0, fe_cnt = 0;
  logic [8:0] rx_q[$];
  logic [7:0] mo_b[8], offer_d[8];
  logic offer_v[8];
  mlaccel_spi_slave dut (
    .clock(clock), .resetn(resetn), .spi_csb(spi_csb), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_first(rx_first), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_active(frame_active), .frame_end(frame_end)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (rx_valid) rx_q.push_back({rx_first, rx_data});
    if (tx_ready) tx_cnt++;
    if (frame_end) fe_cnt++;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic xfer(input logic [7:0] mo, input int nb, input bit glitch, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i >= 8 - nb; i--) begin
      spi_clk = 1'b0;
      spi_mosi = mo[i];
      wait_clk(H);
      mi[i] = spi_miso;
      spi_clk = 1'b1;
      if (glitch && i == 4) begin
        wait_clk(3);
        spi_clk = 1'b0;
        wait_clk(1);
        spi_clk = 1'b1;
        wait_clk(H - 4);
      end else wait_clk(H);
    end
  endtask
  task automatic run_frame(input int n, input int gb, input string tag);
    logic [7:0] mi, exp_m;
    int base_rx, base_tx, base_fe;
    base_rx = rx_q.size();
    base_tx = tx_cnt;
    base_fe = fe_cnt;
    exp_m = IDLE;
    spi_csb = 1'b0;
    wait_clk(H);
    chk($sformatf("%s_active", tag), frame_active, 1);
    chk($sformatf("%s_oe_on", tag), spi_miso_oe, 1);
    for (int k = 0; k < n; k++) begin
      tx_valid = offer_v[k];
      tx_data = offer_d[k];
      xfer(mo_b[k], 8, k == gb, mi);
      chk($sformatf("%s_miso%0d", tag, k), mi, exp_m);
      exp_m = offer_v[k] ? offer_d[k] : IDLE;
    end
    tx_valid = 1'b0;
    spi_csb = 1'b1;
    wait_clk(2 * H);
    chk($sformatf("%s_rx_count", tag), rx_q.size() - base_rx, n);
    for (int k = 0; k < n; k++)
      if (base_rx + k < rx_q.size())
        chk($sformatf("%s_rx%0d", tag, k), rx_q[base_rx + k], {k == 0, mo_b[k]});
    chk($sformatf("%s_tx_ready", tag), tx_cnt - base_tx, n);
    chk($sformatf("%s_frame_end", tag), fe_cnt - base_fe, 1);
    chk($sformatf("%s_inactive", tag), frame_active, 0);
    chk($sformatf("%s_oe_off", tag), spi_miso_oe, 0);
    chk($sformatf("%s_miso_idle", tag), spi_miso, 0);
  endtask
  task automatic check_reset_values(input string tag);
    chk({tag, "_miso"}, spi_miso, 0);
    chk({tag, "_oe"}, spi_miso_oe, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_first"}, rx_first, 0);
    chk({tag, "_tx_ready"}, tx_ready, 0);
    chk({tag, "_frame_active"}, frame_active, 0);
    chk({tag, "_frame_end"}, frame_end, 0);
  endtask
  initial begin
    logic [7:0] mi;
    int base_rx, base_tx, base_fe;
    wait_clk(4);
    check_reset_values("reset");
    resetn = 1'b1;
    wait_clk(H);
    for (int k = 0; k < 8; k++) begin
      offer_v[k] = 1'b0;
      offer_d[k] = 8'h00;
    end
    mo_b[0] = 8'h21;
    mo_b[1] = 8'h05;
    run_frame(2, -1, "two_bytes");
    mo_b[0] = 8'h23;
    mo_b[1] = 8'h00;
    offer_v[0] = 1'b1;
    offer_d[0] = 8'hA5;
    run_frame(2, -1, "tx_a5");
    offer_v[0] = 1'b0;
    for (int k = 0; k < 3; k++) mo_b[k] = 8'($urandom);
    run_frame(3, -1, "tx_idle");
    mo_b[0] = 8'h5A;
    run_frame(1, 0, "glitch");
    base_rx = rx_q.size();
    base_fe = fe_cnt;
    spi_csb = 1'b0;
    wait_clk(H);
    xfer(8'hC3, 5, 1'b0, mi);
    spi_csb = 1'b1;
    wait_clk(2 * H);
    chk("partial_no_rx", rx_q.size() - base_rx, 0);
    chk("partial_frame_end", fe_cnt - base_fe, 1);
    mo_b[0] = 8'h3C;
    run_frame(1, -1, "after_partial");
    base_rx = rx_q.size();
    base_tx = tx_cnt;
    base_fe = fe_cnt;
    spi_csb = 1'b0;
    wait_clk(H);
    xfer(8'hFF, 3, 1'b0, mi);
    resetn = 1'b0;
    wait_clk(2);
    check_reset_values("midreset");
    resetn = 1'b1;
    xfer(8'h81, 8, 1'b0, mi);
    xfer(8'h7E, 8, 1'b0, mi);
    chk("midreset_no_rx", rx_q.size() - base_rx, 0);
    chk("midreset_no_tx_ready", tx_cnt - base_tx, 0);
    chk("midreset_inactive", frame_active, 0);
    spi_csb = 1'b1;
    wait_clk(2 * H);
    chk("midreset_no_frame_end", fe_cnt - base_fe, 0);
    mo_b[0] = 8'h96;
    mo_b[1] = 8'h4B;
    run_frame(2, -1, "post_reset");
    for (int f = 0; f < 12; f++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        mo_b[k] = 8'($urandom);
        offer_v[k] = 1'($urandom);
        offer_d[k] = 8'($urandom);
      end
      run_frame(n, int'($urandom_range(0, 5)) - 2, $sformatf("rand%0d", f));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
